uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver; consumes the o_tx line driven by uart_tx (loopback/peer link).

---
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: OVS-times oversampled line, majority vote at mid-cell,
// stop-bit check and a valid/ready holding register with framing/overrun pulses.
module uart_rx #(
    parameter int OVS      = 16,
    parameter int SYNC_STG = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_bd_x16,
    input  logic       i_rx,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] T_V0  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] T_V1  = TW'(OVS / 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVS / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_WAIT  = 3'd4
    } state_t;

    state_t              state;
    logic [SYNC_STG-1:0] sync_q;
    logic                rx_s;
    logic [TW-1:0]       tcnt;
    logic [2:0]          bitcnt;
    logic [7:0]          shift;
    logic                v0;
    logic                v1;
    logic                vote;
    logic                commit_p1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Input synchronizer, preset to the idle level so reset never fakes a start bit
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], i_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STG-1];
    assign vote = majority3(v0, v1, rx_s);

    // Bit-cell FSM; tcnt holds the index of the tick about to be processed
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= R_IDLE;
            tcnt        <= '0;
            bitcnt      <= '0;
            shift       <= '0;
            v0          <= 1'b1;
            v1          <= 1'b1;
            commit_p1   <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            commit_p1   <= 1'b0;
            o_frame_err <= 1'b0;
            if (i_bd_x16) begin
                if (tcnt == T_V0) v0 <= rx_s;
                if (tcnt == T_V1) v1 <= rx_s;
                case (state)
                    R_IDLE: begin
                        if (!rx_s) begin
                            // the detecting tick is tick 0 of the start cell
                            state  <= R_START;
                            tcnt   <= TW'(1);
                            o_busy <= 1'b1;
                        end
                    end
                    R_START: begin
                        if (tcnt == T_DEC && vote) begin
                            state  <= R_IDLE;
                            tcnt   <= '0;
                            o_busy <= 1'b0;
                        end else if (tcnt == T_END) begin
                            state  <= R_DATA;
                            tcnt   <= '0;
                            bitcnt <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    R_DATA: begin
                        if (tcnt == T_DEC) shift <= {vote, shift[7:1]};
                        if (tcnt == T_END) begin
                            tcnt <= '0;
                            if (bitcnt == 3'd7) begin
                                state <= R_STOP;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    R_STOP: begin
                        if (tcnt == T_DEC) begin
                            tcnt <= '0;
                            if (vote) begin
                                // leave mid-stop so an immediate next start edge is caught
                                commit_p1 <= 1'b1;
                                state     <= R_IDLE;
                                o_busy    <= 1'b0;
                            end else begin
                                o_frame_err <= 1'b1;
                                state       <= R_WAIT;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    R_WAIT: begin
                        if (rx_s) begin
                            state  <= R_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= R_IDLE;
                        tcnt   <= '0;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Holding register: handshake runs every clock, independent of ticks
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (commit_p1) begin
                if (!o_rx_valid || i_rx_ready) begin
                    o_rx_data  <= shift;
                    o_rx_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a byte-level expectation model of uart_rx.
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk;
    logic       rst_n;
    logic       bd;
    logic       rx;
    logic       ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_vec = 0;
    int         n_err = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         exp_fe = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    uart_rx #(.OVS(16), .SYNC_STG(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_bd_x16   (bd),
        .i_rx       (rx),
        .i_rx_ready (ready),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .o_frame_err(frame_err),
        .o_overrun  (overrun),
        .o_busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int ph;
        ph = 0;
        bd = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            bd = (ph == 0);
        end
    end

    // Byte/pulse monitor samples after all negedge-driven inputs have settled
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rx_valid && ready) rxq.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nstop, input logic stop_v);
        rx = 1'b0;
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            clks(BIT);
        end
        rx = stop_v;
        clks(BIT);
        rx = 1'b1;
        if (nstop > 1) clks(BIT * (nstop - 1));
    endtask

    task automatic wait_busy(input logic lvl, input int bound);
        int k;
        k = 0;
        while (busy !== lvl && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_rx(input string tag);
        int k;
        int n;
        k = 0;
        while (rxq.size() < expq.size() && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_count"}, rxq.size(), expq.size());
        n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rxq[i], expq[i]);
        end
        rxq.delete();
        expq.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] lb [4];
        int         ns;
        logic       bad;
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h80; lb[3] = 8'h01;

        // Reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        clks(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        clks(8);

        // 1: byte held until accepted, one-clock handshake
        send_frame(8'hA5, 1, 1'b1);
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'hA5);
        clks(20);
        chk("t1_hold", rx_valid, 1);
        ready = 1'b1;
        clks(1);
        ready = 1'b0;
        chk("t1_cleared", rx_valid, 0);
        expq.push_back(8'hA5);
        check_rx("t1");

        // 2: short low glitch rejected by the start vote
        rx = 1'b0;
        clks(12);
        chk("t2_busy_up", busy, 1);
        clks(8);
        rx = 1'b1;
        clks(BIT);
        chk("t2_busy_down", busy, 0);
        chk("t2_valid", rx_valid, 0);
        chk("t2_ferr", fe_cnt, exp_fe);
        chk("t2_ovr", ov_cnt, 0);
        check_rx("t2");

        // 3: break condition, then recovery
        ready = 1'b1;
        rx = 1'b0;
        clks(20 * BIT);
        exp_fe++;
        chk("t3_ferr_once", fe_cnt, exp_fe);
        chk("t3_wait_busy", busy, 1);
        chk("t3_no_byte", rxq.size(), 0);
        rx = 1'b1;
        clks(BIT);
        chk("t3_idle", busy, 0);
        send_frame(8'h5A, 1, 1'b1);
        expq.push_back(8'h5A);
        check_rx("t3");
        chk("t3_ferr_total", fe_cnt, exp_fe);

        // 4: overrun drops the new byte; ready on the commit clock replaces it
        ready = 1'b0;
        send_frame(8'h11, 1, 1'b1);
        send_frame(8'h22, 1, 1'b1);
        chk("t4_data", rx_data, 8'h11);
        chk("t4_valid", rx_valid, 1);
        chk("t4_ovr_once", ov_cnt, 1);
        fork
            send_frame(8'h22, 1, 1'b1);
            begin
                wait_busy(1'b1, 4 * BIT);
                wait_busy(1'b0, 12 * BIT);
                ready = 1'b1;
                clks(1);
                ready = 1'b0;
            end
        join
        chk("t4_data2", rx_data, 8'h22);
        chk("t4_valid2", rx_valid, 1);
        chk("t4_no_ovr", ov_cnt, 1);
        expq.push_back(8'h11);
        check_rx("t4");

        // 6: reset in the middle of data bit 3 while a byte is pending
        rx = 1'b0; clks(BIT);
        rx = 1'b0; clks(BIT);
        rx = 1'b0; clks(BIT);
        rx = 1'b1; clks(BIT);
        rx = 1'b1; clks(BIT / 2);
        chk("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        clks(1);
        rst_n = 1'b1;
        chk_outputs_zero("t6_rst");
        clks(BIT / 2 + 2 * BIT);
        ready = 1'b1;
        send_frame(8'h3C, 1, 1'b1);
        expq.push_back(8'h3C);
        check_rx("t6");

        // 5: two-stop back-to-back frames, then one-stop frames
        for (int i = 0; i < 4; i++) begin
            send_frame(lb[i], 2, 1'b1);
            expq.push_back(lb[i]);
        end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1, 1'b1);
            expq.push_back(d);
        end
        check_rx("t5");
        chk("t5_ferr", fe_cnt, exp_fe);
        chk("t5_ovr", ov_cnt, 1);

        // Randomized frames: stop length, idle gaps and occasional bad stop bits
        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom_range(0, 255));
            ns  = int'($urandom_range(1, 2));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(d, ns, !bad);
            if (bad) exp_fe++;
            else expq.push_back(d);
            clks(BIT * int'($urandom_range(0, 2)) + (bad ? BIT : 0));
        end
        clks(BIT);
        check_rx("rand");
        chk("rand_ferr", fe_cnt, exp_fe);
        chk("rand_ovr", ov_cnt, 1);
        chk("rand_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
